hilo_muldiv_unit: RTL and testbench

- Multi-cycle multiply/divide unit holding the architectural HI and LO registers.
- Consumes the two operand words read from the register file (rs → operand_a, rt → operand_b).
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Exposes HI/LO so that MFHI/MFLO results return to the register file write port; busy stalls the pipeline.

---
 rtl/hilo_muldiv_unit.sv | 145 ++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Shift-add multiply and restoring divide run on magnitudes; signs are applied in one fix-up cycle.
module hilo_muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned     CntW     = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   hi_q, lo_q, a_q, b_q, a_raw_q;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CntW-1:0]    cnt_q;
    logic               is_div_q, neg_q, rem_neg_q, dz_q, done_q;

    logic               is_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;

    // Even-numbered mult/div opcodes are the signed variants.
    always_comb begin
        is_signed = ~op[0];
        a_neg     = is_signed & operand_a[WIDTH-1];
        b_neg     = is_signed & operand_b[WIDTH-1];
        a_mag     = a_neg ? -operand_a : operand_a;
        b_mag     = b_neg ? -operand_b : operand_b;
    end

    logic [WIDTH:0]   mul_sum, div_sh;
    logic [WIDTH-1:0] div_sub, rem_next;
    logic             div_ge;

    // Multiply: acc = {partial sum, product bits shifted in from the top}.
    // Divide:   acc = {remainder, quotient bits shifted in at the bottom}.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (b_q[0] ? a_q : {WIDTH{1'b0}})};
        div_sh   = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
        div_ge   = div_sh[WIDTH] | (div_sh[WIDTH-1:0] >= b_q);
        div_sub  = div_sh[WIDTH-1:0] - b_q;
        rem_next = div_ge ? div_sub : div_sh[WIDTH-1:0];
        if (is_div_q) begin
            acc_d = {rem_next, acc_q[WIDTH-2:0], div_ge};
        end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo, rem, hi_fix, lo_fix;

    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quo      = acc_q[WIDTH-1:0];
        rem      = acc_q[2*WIDTH-1:WIDTH];
        if (!is_div_q) begin
            hi_fix = prod_fix[2*WIDTH-1:WIDTH];
            lo_fix = prod_fix[WIDTH-1:0];
        end else if (dz_q) begin
            hi_fix = a_raw_q;
            lo_fix = '1;
        end else begin
            hi_fix = rem_neg_q ? -rem : rem;
            lo_fix = neg_q ? -quo : quo;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            hi_q      <= '0;
            lo_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            a_raw_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        case (op)
                            3'b100: hi_q <= operand_a;
                            3'b101: lo_q <= operand_a;
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                a_q       <= a_mag;
                                b_q       <= b_mag;
                                a_raw_q   <= operand_a;
                                is_div_q  <= op[1];
                                neg_q     <= a_neg ^ b_neg;
                                rem_neg_q <= a_neg;
                                dz_q      <= (operand_b == '0);
                                acc_q     <= '0;
                                cnt_q     <= '0;
                                state_q   <= StRun;
                            end
                            default: ;
                        endcase
                    end
                end
                StRun: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CntW'(1);
                    if (is_div_q) begin
                        a_q <= a_q << 1;
                    end else begin
                        b_q <= b_q >> 1;
                    end
                    if (cnt_q == LastIter) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    hi_q    <= hi_fix;
                    lo_q    <= lo_fix;
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: expected {hi,lo} queued at issue, popped at completion.
module tb_hilo_muldiv_unit;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    op = 3'b110;
    logic [W-1:0]  operand_a = '0;
    logic [W-1:0]  operand_b = '0;
    logic          busy, done;
    logic [W-1:0]  hi, lo;

    int            checks = 0;
    int            failures = 0;
    logic [63:0]   sb[$];

    hilo_muldiv_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    // Reference {hi,lo} from native wide arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb_v;
        logic [63:0] r;
        sa   = longint'($signed(a));
        sb_v = longint'($signed(b));
        r    = '0;
        case (o)
            3'd0: r = 64'(sa * sb_v);
            3'd1: r = {32'h0, a} * {32'h0, b};
            3'd2: if (b == 0) r = {a, 32'hFFFFFFFF};
                  else r = {32'(sa % sb_v), 32'(sa / sb_v)};
            3'd3: if (b == 0) r = {a, 32'hFFFFFFFF};
                  else r = {a % b, a / b};
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input bit push);
        @(negedge clk);
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        if (push) sb.push_back(exp);
        @(negedge clk);
        start = 1'b0; op = 3'b110; operand_a = $urandom; operand_b = $urandom;
    endtask

    // Counts busy cycles (bounded); optionally fires a start at busy cycle inj_cycle.
    task automatic wait_result(input int inj_cycle, input logic [2:0] inj_op,
                               input logic [31:0] inj_a, output int cyc, output logic gd);
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            if (cyc == inj_cycle) begin
                start = 1'b1; op = inj_op; operand_a = inj_a; operand_b = $urandom;
            end
            @(negedge clk);
            start = 1'b0;
        end
        gd = done;
    endtask

    task automatic test_reset;
        reset = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo: got %h want 0", lo); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
        reset = 1'b1;
    endtask

    task automatic test_mult;
        logic [2:0]  ops[5];
        logic [31:0] as[5], bs[5];
        logic [63:0] ex[5], want;
        int cyc; logic gd;
        ops[0] = 3'd0; as[0] = 32'hFFFFFFFD; bs[0] = 32'd5;       ex[0] = 64'hFFFFFFFF_FFFFFFF1;
        ops[1] = 3'd1; as[1] = 32'hFFFFFFFF; bs[1] = 32'hFFFFFFFF; ex[1] = 64'hFFFFFFFE_00000001;
        ops[2] = 3'd0; as[2] = 32'hFFFFFFFF; bs[2] = 32'hFFFFFFFF; ex[2] = 64'h00000000_00000001;
        ops[3] = 3'd0; as[3] = $urandom;     bs[3] = $urandom;     ex[3] = model(ops[3], as[3], bs[3]);
        ops[4] = 3'd1; as[4] = $urandom;     bs[4] = $urandom;     ex[4] = model(ops[4], as[4], bs[4]);
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], as[i], bs[i], ex[i], 1'b1);
            wait_result(0, 3'b110, 32'h0, cyc, gd);
            want = sb.pop_front();
            checks++; if (cyc !== 33) begin failures++; $display("FAIL mult_busy[%0d]: got %0d want 33", i, cyc); end
            checks++; if (gd !== 1'b1) begin failures++; $display("FAIL mult_done[%0d]: got %b want 1", i, gd); end
            checks++; if ({hi, lo} !== want) begin
                failures++; $display("FAIL mult_result[%0d]: got %h_%h want %h", i, hi, lo, want);
            end
            @(negedge clk);
            checks++; if (done !== 1'b0) begin failures++; $display("FAIL mult_pulse[%0d]: got %b want 0", i, done); end
        end
    endtask

    task automatic test_div;
        logic [2:0]  ops[7];
        logic [31:0] as[7], bs[7];
        logic [63:0] ex[7], want;
        int cyc; logic gd;
        ops[0] = 3'd2; as[0] = 32'hFFFFFFF9; bs[0] = 32'd2;       ex[0] = 64'hFFFFFFFF_FFFFFFFD;
        ops[1] = 3'd3; as[1] = 32'd100;      bs[1] = 32'd7;       ex[1] = 64'h00000002_0000000E;
        ops[2] = 3'd2; as[2] = 32'h80000000; bs[2] = 32'hFFFFFFFF; ex[2] = 64'h00000000_80000000;
        ops[3] = 3'd3; as[3] = 32'd7;        bs[3] = 32'd0;       ex[3] = 64'h00000007_FFFFFFFF;
        ops[4] = 3'd2; as[4] = 32'hFFFFFFF9; bs[4] = 32'd0;       ex[4] = 64'hFFFFFFF9_FFFFFFFF;
        ops[5] = 3'd2; as[5] = $urandom;
        bs[5] = $urandom_range(1, 5000);
        if ($urandom_range(0, 1) == 1) bs[5] = -bs[5];
        ex[5] = model(ops[5], as[5], bs[5]);
        ops[6] = 3'd3; as[6] = $urandom; bs[6] = $urandom_range(1, 100000);
        ex[6] = model(ops[6], as[6], bs[6]);
        for (int i = 0; i < 7; i++) begin
            issue(ops[i], as[i], bs[i], ex[i], 1'b1);
            wait_result(0, 3'b110, 32'h0, cyc, gd);
            want = sb.pop_front();
            checks++; if (cyc !== 33) begin failures++; $display("FAIL div_busy[%0d]: got %0d want 33", i, cyc); end
            checks++; if (gd !== 1'b1) begin failures++; $display("FAIL div_done[%0d]: got %b want 1", i, gd); end
            checks++; if ({hi, lo} !== want) begin
                failures++; $display("FAIL div_result[%0d]: got %h_%h want %h", i, hi, lo, want);
            end
        end
    endtask

    task automatic test_mthi_mtlo;
        @(negedge clk);
        start = 1'b1; op = 3'b100; operand_a = 32'h12345678;
        @(negedge clk);
        checks++; if (hi !== 32'h12345678) begin failures++; $display("FAIL mthi_hi: got %h want 12345678", hi); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL mthi_flags: got busy=%b done=%b want 0 0", busy, done);
        end
        op = 3'b101; operand_a = 32'h9ABCDEF0;
        @(negedge clk);
        checks++; if (lo !== 32'h9ABCDEF0) begin failures++; $display("FAIL mtlo_lo: got %h want 9abcdef0", lo); end
        checks++; if (hi !== 32'h12345678) begin failures++; $display("FAIL mtlo_hi: got %h want 12345678", hi); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL mtlo_flags: got busy=%b done=%b want 0 0", busy, done);
        end
        op = 3'b111; operand_a = 32'hFFFF0000;
        @(negedge clk);
        start = 1'b0;
        checks++; if ({hi, lo} !== 64'h12345678_9ABCDEF0 || busy !== 1'b0) begin
            failures++; $display("FAIL noop: got %h_%h busy=%b want 12345678_9abcdef0 busy=0", hi, lo, busy);
        end
    endtask

    task automatic test_busy_ignore;
        logic [63:0] want;
        int cyc; logic gd;
        issue(3'd1, 32'd3, 32'd4, 64'h00000000_0000000C, 1'b1);
        wait_result(10, 3'b101, 32'h0000DEAD, cyc, gd);
        want = sb.pop_front();
        checks++; if (cyc !== 33) begin failures++; $display("FAIL ignore_busy: got %0d want 33", cyc); end
        checks++; if (gd !== 1'b1) begin failures++; $display("FAIL ignore_done: got %b want 1", gd); end
        checks++; if ({hi, lo} !== want) begin
            failures++; $display("FAIL ignore_result: got %h_%h want %h", hi, lo, want);
        end
    endtask

    task automatic test_reset_midop;
        logic seen;
        @(negedge clk);
        start = 1'b1; op = 3'b100; operand_a = 32'hA5A5A5A5;
        @(negedge clk);
        start = 1'b0; op = 3'b110;
        issue(3'd0, 32'd6, 32'd7, 64'h0, 1'b0);
        for (int c = 1; c < 20 && busy === 1'b1; c++) @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midop_busy: got %b want 1", busy); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if ({hi, lo} !== 64'h0) begin failures++; $display("FAIL midop_hilo: got %h_%h want 0_0", hi, lo); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL midop_flags: got busy=%b done=%b want 0 0", busy, done);
        end
        reset = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midop_discard: got activity=%b want 0", seen); end
    endtask

    task automatic test_back_to_back;
        logic [63:0] want;
        int cyc; logic gd;
        issue(3'd3, 32'd9, 32'd3, 64'h00000000_00000003, 1'b1);
        wait_result(0, 3'b110, 32'h0, cyc, gd);
        want = sb.pop_front();
        checks++; if (cyc !== 33) begin failures++; $display("FAIL b2b_busy0: got %0d want 33", cyc); end
        checks++; if (gd !== 1'b1) begin failures++; $display("FAIL b2b_done0: got %b want 1", gd); end
        checks++; if ({hi, lo} !== want) begin
            failures++; $display("FAIL b2b_result0: got %h_%h want %h", hi, lo, want);
        end
        // New request driven during the done cycle.
        start = 1'b1; op = 3'b010; operand_a = 32'h80000000; operand_b = 32'hFFFFFFFF;
        sb.push_back(64'h00000000_80000000);
        @(negedge clk);
        start = 1'b0; op = 3'b110;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept: got busy=%b want 1", busy); end
        wait_result(0, 3'b110, 32'h0, cyc, gd);
        want = sb.pop_front();
        checks++; if (cyc !== 33) begin failures++; $display("FAIL b2b_busy1: got %0d want 33", cyc); end
        checks++; if (gd !== 1'b1) begin failures++; $display("FAIL b2b_done1: got %b want 1", gd); end
        checks++; if ({hi, lo} !== want) begin
            failures++; $display("FAIL b2b_result1: got %h_%h want %h", hi, lo, want);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_busy_ignore();
        test_reset_midop();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
